// File: rtl/sseg_pkg.sv
// Seven-segment encoding constants shared by the display slice.
package sseg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   typedef logic [NIB_W-1:0] nibble_t;
   typedef logic [SEG_W-1:0] seg_t;

   // Active-low gfedcba patterns indexed by hex value.
   localparam seg_t SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam seg_t BLANK = 7'h7F;

endpackage

// File: rtl/sseg_multi_display_if.sv
// Bus bundle between the display block and its host.
interface sseg_multi_display_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  sel;
   logic [4*DIGITS-1:0]   data_in;
   logic [4*DIGITS-1:0]   data_out;
   logic                  load;
   logic [DIGITS-1:0]     blink_en;
   logic                  blank;
   logic [7*DIGITS-1:0]   seg;
   logic                  ack;

   modport master (
      output sel, data_in, data_out, load, blink_en, blank,
      input  seg, ack
   );

   modport slave (
      input  sel, data_in, data_out, load, blink_en, blank,
      output seg, ack
   );
endinterface

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low segment decoder.
module hex_to_sseg
   import sseg_pkg::*;
(
   input  nibble_t nibble,
   output seg_t    seg_c
);

   // Table lookup of the segment pattern.
   always_comb begin
      seg_c = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/sseg_multi_display.sv
// Multi-digit hex display: shadow capture, blink, leading-zero blanking.
module sseg_multi_display
   import sseg_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned BLINK_DIV   = 25_000_000,
   parameter int unsigned LZ_SUPPRESS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   sseg_multi_display_if.slave  bus
);

   localparam int unsigned DATA_W = NIB_W * DIGITS;
   localparam int unsigned OUT_W  = SEG_W * DIGITS;
   localparam int unsigned CNT_W  = $clog2(BLINK_DIV);

   logic [DATA_W-1:0] shadow;
   logic [CNT_W-1:0]  cnt;
   logic              phase;
   logic [DIGITS-1:0] lz;
   logic              nz_above;
   seg_t              dec [DIGITS];
   logic [OUT_W-1:0]  seg_next;

   // Shadow register and capture acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         bus.ack <= 1'b0;
      end else begin
         bus.ack <= bus.load;
         if (bus.load) begin
            shadow <= bus.sel ? bus.data_out : bus.data_in;
         end
      end
   end

   // Free-running blink divider; phase flips on each wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // One decoder per digit.
   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
      hex_to_sseg u_dec (
         .nibble (shadow[NIB_W*g +: NIB_W]),
         .seg_c  (dec[g])
      );
   end

   // Leading-zero mask: digit i blanks if it and every digit above are zero; digit 0 never blanks.
   always_comb begin
      lz       = '0;
      nz_above = 1'b0;
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
         if (shadow[NIB_W*i +: NIB_W] != nibble_t'(0)) begin
            nz_above = 1'b1;
         end
         lz[i] = (LZ_SUPPRESS != 0) && !nz_above;
      end
   end

   // Per-digit priority: blank, blink-off, leading zero, decoded value.
   always_comb begin
      seg_next = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bus.blank) begin
            seg_next[SEG_W*i +: SEG_W] = BLANK;
         end else if (bus.blink_en[i] && phase) begin
            seg_next[SEG_W*i +: SEG_W] = BLANK;
         end else if (lz[i]) begin
            seg_next[SEG_W*i +: SEG_W] = BLANK;
         end else begin
            seg_next[SEG_W*i +: SEG_W] = dec[i];
         end
      end
   end

   // Registered segment outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.seg <= {DIGITS{BLANK}};
      end else begin
         bus.seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_sseg_multi_display.sv
// Self-checking bench: vector table, corner sequences and random run vs. reference model.
module tb_sseg_multi_display;

   localparam int unsigned BDIV = 4;

   logic        clk;
   logic        rst;
   logic        sel;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        load;
   logic [3:0]  blink_en;
   logic        blank;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [15:0] m_shadow;
   int          m_k;

   sseg_multi_display_if #(.DIGITS(4)) bus_a ();
   sseg_multi_display_if #(.DIGITS(4)) bus_b ();

   assign bus_a.sel = sel;       assign bus_b.sel = sel;
   assign bus_a.data_in = data_in;   assign bus_b.data_in = data_in;
   assign bus_a.data_out = data_out; assign bus_b.data_out = data_out;
   assign bus_a.load = load;     assign bus_b.load = load;
   assign bus_a.blink_en = blink_en; assign bus_b.blink_en = blink_en;
   assign bus_a.blank = blank;   assign bus_b.blank = blank;

   sseg_multi_display #(.DIGITS(4), .BLINK_DIV(BDIV), .LZ_SUPPRESS(1)) dut_lz (
      .clk (clk), .rst (rst), .bus (bus_a)
   );

   sseg_multi_display #(.DIGITS(4), .BLINK_DIV(BDIV), .LZ_SUPPRESS(0)) dut_nz (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   // Blink phase after k edges: toggles once every BDIV edges.
   function automatic logic phase_at(input int k);
      return ((k / BDIV) % 2) == 1;
   endfunction

   function automatic logic [27:0] exp_seg(input logic [15:0] val, input logic ph,
                                           input logic [3:0] ben, input logic blk,
                                           input logic lz_en);
      logic [27:0] r;
      int msd;
      r   = '0;
      msd = 0;
      for (int i = 0; i < 4; i++) if (val[4*i +: 4] != 4'h0) msd = i;
      for (int i = 0; i < 4; i++) begin
         if (blk)                     r[7*i +: 7] = 7'h7F;
         else if (ben[i] && ph)       r[7*i +: 7] = 7'h7F;
         else if (lz_en && i > msd)   r[7*i +: 7] = 7'h7F;
         else                         r[7*i +: 7] = hex7(val[4*i +: 4]);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
   endtask

   // One clock edge with model update and comparison at the following negedge.
   task automatic cycle(input string tag);
      logic [27:0] ea, eb;
      logic        eack;
      ea   = exp_seg(m_shadow, phase_at(m_k), blink_en, blank, 1'b1);
      eb   = exp_seg(m_shadow, phase_at(m_k), blink_en, blank, 1'b0);
      eack = load;
      if (load) m_shadow = sel ? data_out : data_in;
      m_k++;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".seg_lz"}, 32'(bus_a.seg), 32'(ea));
      chk({tag, ".seg_nz"}, 32'(bus_b.seg), 32'(eb));
      chk({tag, ".ack_lz"}, 32'(bus_a.ack), 32'(eack));
      chk({tag, ".ack_nz"}, 32'(bus_b.ack), 32'(eack));
   endtask

   typedef struct {
      logic        sel;
      logic [15:0] din;
      logic [15:0] dout;
      logic [27:0] exp_lz;
      logic [27:0] exp_nz;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1'b0, 16'h12AF, 16'h0000, {7'h79,7'h24,7'h08,7'h0E}, {7'h79,7'h24,7'h08,7'h0E}};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0030, {7'h7F,7'h7F,7'h30,7'h40}, {7'h40,7'h40,7'h30,7'h40}};
      vecs[2] = '{1'b0, 16'h0000, 16'h9999, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}};
      vecs[3] = '{1'b1, 16'h0001, 16'h8000, {7'h00,7'h40,7'h40,7'h40}, {7'h00,7'h40,7'h40,7'h40}};
      vecs[4] = '{1'b0, 16'h0005, 16'h1234, {7'h7F,7'h7F,7'h7F,7'h12}, {7'h40,7'h40,7'h40,7'h12}};
      vecs[5] = '{1'b1, 16'h0000, 16'h0F0D, {7'h7F,7'h0E,7'h40,7'h21}, {7'h40,7'h0E,7'h40,7'h21}};

      rst = 1'b0; sel = 1'b0; data_in = '0; data_out = '0;
      load = 1'b0; blink_en = '0; blank = 1'b0;
      m_shadow = '0; m_k = 0;
      #2 rst = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst.seg_lz", 32'(bus_a.seg), 32'h0FFF_FFFF);
      chk("rst.seg_nz", 32'(bus_b.seg), 32'h0FFF_FFFF);
      chk("rst.ack", 32'(bus_a.ack), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_shadow = '0; m_k = 0;

      // Vector table: load pulse, ack next cycle, seg two edges after load
      foreach (vecs[v]) begin
         sel = vecs[v].sel; data_in = vecs[v].din; data_out = vecs[v].dout; load = 1'b1;
         cycle("vec.load");
         chk("vec.ack", 32'(bus_a.ack), 32'h1);
         load = 1'b0;
         cycle("vec.show");
         chk("vec.tbl_lz", 32'(bus_a.seg), 32'(vecs[v].exp_lz));
         chk("vec.tbl_nz", 32'(bus_b.seg), 32'(vecs[v].exp_nz));
         chk("vec.ack_drop", 32'(bus_a.ack), 32'h0);
      end

      // Held load recaptures every cycle with ack staying high
      sel = 1'b0; load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'(16'h1000 * (i + 1) + 16'h0003);
         cycle("held");
      end
      load = 1'b0;
      cycle("held.end");

      // Blink digit 0 on 1111
      sel = 1'b0; data_in = 16'h1111; load = 1'b1; blink_en = 4'b0001;
      cycle("blink.load");
      load = 1'b0;
      for (int i = 0; i < 20; i++) cycle("blink");

      // Blank with simultaneous load of 5555
      blink_en = '0; blank = 1'b1; data_in = 16'h5555; load = 1'b1;
      cycle("blank.load");
      chk("blank.all7f", 32'(bus_a.seg), 32'h0FFF_FFFF);
      chk("blank.ack", 32'(bus_a.ack), 32'h1);
      load = 1'b0;
      cycle("blank.hold");
      chk("blank.still7f", 32'(bus_a.seg), 32'h0FFF_FFFF);
      blank = 1'b0;
      cycle("blank.drop");
      chk("blank.shows5", 32'(bus_a.seg), 32'({7'h12,7'h12,7'h12,7'h12}));

      // Reset in the middle of the blink-off phase
      data_in = 16'h8888; load = 1'b1; blink_en = 4'b0001;
      cycle("rstblink.load");
      load = 1'b0;
      for (int i = 0; i < 2 * BDIV && !(phase_at(m_k - 1) && phase_at(m_k)); i++) cycle("rstblink.wait");
      chk("rstblink.offphase", 32'(bus_a.seg), 32'({7'h00,7'h00,7'h00,7'h7F}));
      load = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstblink.imm_lz", 32'(bus_a.seg), 32'h0FFF_FFFF);
      chk("rstblink.imm_nz", 32'(bus_b.seg), 32'h0FFF_FFFF);
      chk("rstblink.ack", 32'(bus_a.ack), 32'h0);
      @(negedge clk);
      @(negedge clk);
      load = 1'b0;
      rst = 1'b0;
      m_shadow = '0; m_k = 0;
      cycle("rstblink.first");
      chk("rstblink.first_lz", 32'(bus_a.seg), 32'({7'h7F,7'h7F,7'h7F,7'h40}));
      for (int i = 0; i < 12; i++) cycle("rstblink.after");

      // Randomized traffic against the reference model
      for (int n = 0; n < 300; n++) begin
         sel      = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 2) == 0);
         blank    = ($urandom_range(0, 5) == 0);
         blink_en = 4'($urandom);
         for (int d = 0; d < 4; d++) begin
            data_in[4*d +: 4]  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            data_out[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
         end
         cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sseg_multi_display.md
SSEG_MULTI_DISPLAY -- requirements
Module: sseg_multi_display

Interface
REQ-001 Parameter DIGITS, default 4: number of hex digits driven (1..8).
REQ-002 Parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period (>=2).
REQ-003 Parameter LZ_SUPPRESS, default 1: 1 enables leading-zero blanking.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sel  input  1  source select: 1 = data_out bus, 0 = data_in bus.
REQ-007 data_in  input  4*DIGITS  nibble per digit, digit 0 in bits [3:0].
REQ-008 data_out  input  4*DIGITS  nibble per digit, same packing.
REQ-009 load  input  1  capture request, one-cycle pulse or level.
REQ-010 blink_en  input  DIGITS  per-digit blink enable.
REQ-011 blank  input  1  force all digits off while high.
REQ-012 seg  output  7*DIGITS  active-low segments gfedcba per digit, digit 0 in [6:0], registered.
REQ-013 ack  output  1  high one cycle after each captured load.

Function
REQ-014 On rising clk with load=1, the shadow register SHALL capture data_out if sel=1, else data_in; sel is sampled only in the same cycle.
REQ-015 With load=0 the shadow register SHALL hold its value.
REQ-016 ack SHALL be high in the cycle after each capture edge; load held high SHALL recapture every cycle, keeping ack high.
REQ-017 seg SHALL reflect a newly captured value two edges after the load edge (shadow, then output register).
REQ-018 Decoding SHALL be active-low: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex).
REQ-019 Blank digit code SHALL be 7F.
REQ-020 Blink counter SHALL count 0..BLINK_DIV-1, wrap to 0, and toggle a phase bit on the wrap.
REQ-021 Digit i SHALL show 7F when blink_en[i]=1 and phase=1; otherwise its decoded value.
REQ-022 With LZ_SUPPRESS=1, each zero digit above the most significant non-zero digit SHALL show 7F; digit 0 SHALL always display (all-zero shows a single 0).
REQ-023 blank=1 SHALL force all digits to 7F on the next edge; shadow capture and blink counter SHALL continue unaffected.
REQ-024 Priority per digit: blank, then blink-off phase, then leading-zero suppression, then decoded value.
REQ-025 Simultaneous load and blank: capture proceeds, ack asserts, outputs stay 7F until blank drops.
REQ-026 blink_en changes SHALL take effect on the next output edge without resetting the counter.

Reset
REQ-027 While rst=1: shadow = 0, blink counter = 0, phase = 0, ack = 0, every seg digit = 7F.
REQ-028 rst asserted mid-blink or mid-load SHALL abandon the capture; after release, the first output edge shows digit 0 as 40 and other digits per REQ-022.

Structure
REQ-029 Package sseg_pkg SHALL hold the 16-entry segment encoding constants and the BLANK (7F) constant.
REQ-030 Sub-module hex_to_sseg (4-bit in, 7-bit out, combinational) SHALL be instantiated DIGITS times.
REQ-031 Blink counter width SHALL be $clog2(BLINK_DIV), sized by parameter, no magic widths.

Verification
REQ-032 DIGITS=4: sel=0, data_in=16'h12AF, load pulse -> ack next cycle; seg = {79,24,08,0E} (digit3..0) two edges after load.
REQ-033 sel=1, data_out=16'h0030, data_in=16'hFFFF, load -> digits 3,2 = 7F, digit1 = 30, digit0 = 40; LZ_SUPPRESS=0 -> {40,40,30,40}.
REQ-034 BLINK_DIV=4, blink_en=4'b0001, value 16'h1111 -> digit0 alternates 79/7F every 4 cycles; digits 1..3 steady 79.
REQ-035 blank=1 with a simultaneous load of 16'h5555 -> all 7F, ack=1; blank drops -> all digits 12 next edge.
REQ-036 rst asserted mid blink-off phase with value 16'h8888 -> seg all 7F immediately; after release -> {7F,7F,7F,40}, counter restarts at 0.
